// File: rtl/power_status_display_if.sv
// Bundle between the power controller and the display back-end: live status/values in,
// multiplexed 7-segment drive out.
interface power_status_display_if;
   logic       power_status;
   logic [7:0] selection;
   logic [7:0] left_time;
   logic [7:0] right_time;
   logic [7:0] seg_out;
   logic [7:0] seg_en;

   modport master (
      output power_status, selection, left_time, right_time,
      input  seg_out, seg_en
   );

   modport slave (
      input  power_status, selection, left_time, right_time,
      output seg_out, seg_en
   );
endinterface

// File: rtl/power_status_display.sv
// 8-digit multiplexed 7-segment back-end: timed "On"/"OFF" messages around power transitions,
// live hex selection and saturated decimal timers while running, dark while off.
module power_status_display #(
   parameter int unsigned SCAN_DIV = 100_000,
   parameter int unsigned MSG_TIME = 100_000_000
) (
   input logic                   clk,
   input logic                   rst,
   power_status_display_if.slave bus
);
   localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned MW = (MSG_TIME > 1) ? $clog2(MSG_TIME) : 1;
   localparam logic [PW-1:0] PreLast = PW'(SCAN_DIV - 1);
   localparam logic [PW-1:0] PreOne  = PW'(1);
   localparam logic [MW-1:0] MsgLoad = MW'(MSG_TIME - 1);
   localparam logic [MW-1:0] MsgOne  = MW'(1);

   localparam logic [7:0] SegO = 8'b1111_1100;
   localparam logic [7:0] SegN = 8'b0010_1010;
   localparam logic [7:0] SegF = 8'b1000_1110;

   typedef enum logic [1:0] {StOff, StBoot, StRun, StShutdown} state_e;

   state_e        state_q;
   logic [PW-1:0] prescaler_q;
   logic [2:0]    scan_idx_q;
   logic [MW-1:0] msg_cnt_q;
   logic [7:0]    seg_out_q;
   logic [7:0]    seg_en_q;
   logic          tick;
   logic [7:0]    digit_pat;
   logic [7:0]    lt_bcd;
   logic [7:0]    rt_bcd;

   function automatic logic [7:0] hex_seg(input logic [3:0] n);
      unique case (n)
         4'h0: hex_seg = 8'hFC;
         4'h1: hex_seg = 8'h60;
         4'h2: hex_seg = 8'hDA;
         4'h3: hex_seg = 8'hF2;
         4'h4: hex_seg = 8'h66;
         4'h5: hex_seg = 8'hB6;
         4'h6: hex_seg = 8'hBE;
         4'h7: hex_seg = 8'hE0;
         4'h8: hex_seg = 8'hFE;
         4'h9: hex_seg = 8'hE6;
         4'hA: hex_seg = 8'hEE;
         4'hB: hex_seg = 8'h3E;
         4'hC: hex_seg = 8'h9C;
         4'hD: hex_seg = 8'h7A;
         4'hE: hex_seg = 8'h9E;
         default: hex_seg = 8'h8E;
      endcase
   endfunction

   // Returns {tens, units}; anything above 99 reads as 99.
   function automatic logic [7:0] dec2(input logic [7:0] v);
      logic [7:0] sat;
      sat  = (v > 8'd99) ? 8'd99 : v;
      dec2 = {4'(sat / 8'd10), 4'(sat % 8'd10)};
   endfunction

   assign tick = (prescaler_q == PreLast);

   always_comb begin
      lt_bcd    = dec2(bus.left_time);
      rt_bcd    = dec2(bus.right_time);
      digit_pat = 8'h00;
      unique case (state_q)
         StBoot: begin
            if (scan_idx_q == 3'd1)      digit_pat = SegO;
            else if (scan_idx_q == 3'd0) digit_pat = SegN;
         end
         StShutdown: begin
            if (scan_idx_q == 3'd2)       digit_pat = SegO;
            else if (scan_idx_q <= 3'd1)  digit_pat = SegF;
         end
         StRun: begin
            case (scan_idx_q)
               3'd7:    digit_pat = hex_seg(bus.selection[7:4]);
               3'd6:    digit_pat = hex_seg(bus.selection[3:0]);
               3'd3:    digit_pat = hex_seg(lt_bcd[7:4]);
               3'd2:    digit_pat = hex_seg(lt_bcd[3:0]);
               3'd1:    digit_pat = hex_seg(rt_bcd[7:4]);
               3'd0:    digit_pat = hex_seg(rt_bcd[3:0]);
               default: digit_pat = 8'h00;
            endcase
         end
         default: digit_pat = 8'h00;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StOff;
         prescaler_q <= '0;
         scan_idx_q  <= 3'd0;
         msg_cnt_q   <= '0;
         seg_out_q   <= 8'h00;
         seg_en_q    <= 8'h00;
      end else begin
         prescaler_q <= tick ? '0 : prescaler_q + PreOne;
         if (tick) scan_idx_q <= scan_idx_q + 3'd1;

         unique case (state_q)
            StOff: begin
               if (bus.power_status) begin
                  state_q   <= StBoot;
                  msg_cnt_q <= MsgLoad;
               end
            end
            StBoot: begin
               if (!bus.power_status) begin
                  state_q   <= StShutdown;
                  msg_cnt_q <= MsgLoad;
               end else if (msg_cnt_q == '0) begin
                  state_q <= StRun;
               end else begin
                  msg_cnt_q <= msg_cnt_q - MsgOne;
               end
            end
            StRun: begin
               if (!bus.power_status) begin
                  state_q   <= StShutdown;
                  msg_cnt_q <= MsgLoad;
               end
            end
            StShutdown: begin
               if (bus.power_status) begin
                  state_q   <= StBoot;
                  msg_cnt_q <= MsgLoad;
               end else if (msg_cnt_q == '0) begin
                  state_q <= StOff;
               end else begin
                  msg_cnt_q <= msg_cnt_q - MsgOne;
               end
            end
            default: state_q <= StOff;
         endcase

         // Enable follows the scan slot in every lit state, even over blank digits.
         seg_en_q  <= (state_q == StOff) ? 8'h00 : (8'h01 << scan_idx_q);
         seg_out_q <= (state_q == StOff) ? 8'h00 : digit_pat;
      end
   end

   assign bus.seg_out = seg_out_q;
   assign bus.seg_en  = seg_en_q;
endmodule

// File: tb/tb_power_status_display.sv
// Bench for power_status_display: digit tables for RUN content, hand sequences for the message
// dwell/abort/reset corners, and a randomized run against a cycle-count based reference model.
module tb_power_status_display;
   localparam int unsigned SCAN_DIV = 4;
   localparam int unsigned MSG_TIME = 20;

   localparam logic [7:0] FONT [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                                        8'hFE, 8'hE6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};

   typedef enum int {MOff, MBoot, MRun, MShut} mode_e;

   typedef struct {
      logic [7:0]  sel;
      logic [7:0]  lt;
      logic [7:0]  rt;
      logic [63:0] digits;  // digit i at [i*8 +: 8]
   } run_vec_t;

   logic clk;
   logic rst;
   power_status_display_if bus ();

   power_status_display #(
      .SCAN_DIV (SCAN_DIV),
      .MSG_TIME (MSG_TIME)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int    checks   = 0;
   int    failures = 0;
   mode_e mode     = MOff;
   int    enter    = 0;
   int    cyc      = 0;  // active edges since reset release
   int    last_idx = 0;

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cyc %0d mode %0d)", name, got, exp, cyc, mode);
      end
   endtask

   function automatic logic [7:0] dec_seg(input logic [7:0] v, input bit tens);
      int s;
      s = (v > 99) ? 99 : int'(v);
      return tens ? FONT[s / 10] : FONT[s % 10];
   endfunction

   function automatic logic [7:0] exp_digit(input int idx);
      case (mode)
         MBoot: return (idx == 1) ? 8'hFC : (idx == 0) ? 8'h2A : 8'h00;
         MShut: return (idx == 2) ? 8'hFC : (idx <= 1) ? 8'h8E : 8'h00;
         MRun: begin
            case (idx)
               7: return FONT[bus.selection[7:4]];
               6: return FONT[bus.selection[3:0]];
               3: return dec_seg(bus.left_time, 1'b1);
               2: return dec_seg(bus.left_time, 1'b0);
               1: return dec_seg(bus.right_time, 1'b1);
               0: return dec_seg(bus.right_time, 1'b0);
               default: return 8'h00;
            endcase
         end
         default: return 8'h00;
      endcase
   endfunction

   // One clock: predict from pre-edge model state, advance the model, compare after the edge.
   task automatic step();
      int         idx;
      logic [7:0] e_en;
      logic [7:0] e_out;
      idx      = (cyc / SCAN_DIV) % 8;
      last_idx = idx;
      e_en     = (mode == MOff) ? 8'h00 : 8'(1 << idx);
      e_out    = (mode == MOff) ? 8'h00 : exp_digit(idx);
      case (mode)
         MOff:  if (bus.power_status) begin mode = MBoot; enter = cyc; end
         MBoot: begin
            if (!bus.power_status) begin mode = MShut; enter = cyc; end
            else if (cyc - enter == MSG_TIME) mode = MRun;
         end
         MRun:  if (!bus.power_status) begin mode = MShut; enter = cyc; end
         MShut: begin
            if (bus.power_status) begin mode = MBoot; enter = cyc; end
            else if (cyc - enter == MSG_TIME) mode = MOff;
         end
         default: mode = MOff;
      endcase
      cyc++;
      @(posedge clk);
      #1;
      check("seg_en", bus.seg_en, e_en);
      check("seg_out", bus.seg_out, e_out);
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic release_reset();
      @(negedge clk);
      rst   = 1'b1;
      mode  = MOff;
      cyc   = 0;
      enter = 0;
      #4;
   endtask

   run_vec_t vecs [5];

   initial begin
      vecs[0] = '{8'h3A, 8'd57,  8'd150, 64'hF2EE0000B6E0E6E6};
      vecs[1] = '{8'h00, 8'd0,   8'd99,  64'hFCFC0000FCFCE6E6};
      vecs[2] = '{8'hBD, 8'd100, 8'd8,   64'h3E7A0000E6E6FCFE};
      vecs[3] = '{8'hF1, 8'd42,  8'd255, 64'h8E60000066DAE6E6};
      vecs[4] = '{8'hC9, 8'd10,  8'd61,  64'h9CE6000060FCBE60};

      // Reset held with power off: everything dark.
      rst              = 1'b0;
      bus.power_status = 1'b0;
      bus.selection    = 8'h00;
      bus.left_time    = 8'd0;
      bus.right_time   = 8'd0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         check("reset_seg_en", bus.seg_en, 8'h00);
         check("reset_seg_out", bus.seg_out, 8'h00);
      end
      release_reset();
      steps(100);

      // Power-up message, then into RUN.
      bus.power_status = 1'b1;
      steps(24);

      // RUN content across a full 32-cycle scan for each table row.
      for (int v = 0; v < 5; v++) begin
         bus.selection  = vecs[v].sel;
         bus.left_time  = vecs[v].lt;
         bus.right_time = vecs[v].rt;
         for (int c = 0; c < 8 * SCAN_DIV; c++) begin
            step();
            check($sformatf("run_vec%0d_d%0d", v, last_idx), bus.seg_out,
                  vecs[v].digits[last_idx*8 +: 8]);
         end
      end

      // Power-down message for the full dwell, then dark.
      bus.power_status = 1'b0;
      steps(30);
      check("shutdown_dark_en", bus.seg_en, 8'h00);

      // Abort BOOT at msg_cnt=10, return five cycles later.
      bus.power_status = 1'b1;
      steps(10);
      bus.power_status = 1'b0;
      steps(5);
      bus.power_status = 1'b1;
      steps(25);
      check("abort_ends_run", 8'(mode == MRun), 8'h01);

      // Asynchronous reset between edges mid-RUN.
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("async_rst_en", bus.seg_en, 8'h00);
      check("async_rst_out", bus.seg_out, 8'h00);
      @(posedge clk);
      #1;
      check("rst_held_en", bus.seg_en, 8'h00);
      release_reset();
      steps(2);
      check("boot_after_rst", bus.seg_out, 8'h2A);
      steps(30);

      // Randomized power toggles and value changes.
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 27) == 0) bus.power_status = ~bus.power_status;
         if ($urandom_range(0, 9) == 0) bus.selection = 8'($urandom);
         if ($urandom_range(0, 9) == 0) bus.left_time = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 9) == 0) bus.right_time = 8'($urandom_range(80, 120));
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/power_status_display.md
Name: power_status_display

Overview:
Display back-end for the power on/off controller. It consumes `power_status`, `selection`, `left_time` and `right_time`, and drives the board's 8-digit multiplexed 7-segment display.
- Shows a timed "On" message at power-up and a timed "OFF" message at power-down.
- Shows live values while powered.
- Blanks the display while off.

Parameters:
- SCAN_DIV, 100_000: clk cycles per digit slot (1 ms at 100 MHz); must be >= 2.
- MSG_TIME, 100_000_000: clk cycles the "On"/"OFF" message dwells (1 s at 100 MHz); must be >= 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- power_status  input  1  1 = powered on, 0 = off; level-sensitive, already synchronous to clk.
- selection  input  8  current menu selection, displayed as 2 hex digits.
- left_time  input  8  left timer value, displayed as 2 decimal digits.
- right_time  input  8  right timer value, displayed as 2 decimal digits.
- seg_out  output  8  segment pattern, active-high; bit7..0 = a,b,c,d,e,f,g,dp.
- seg_en  output  8  digit enable, one-hot active-high; bit i = digit i; 8'h00 = all dark.

Behaviour:
- Reset (rst=0, async): state=OFF, prescaler=0, scan_idx=0, msg_cnt=0, seg_out=8'h00, seg_en=8'h00.
- Prescaler: counts 0..SCAN_DIV-1 and wraps.
  - tick=1 in the cycle the prescaler equals SCAN_DIV-1.
  - scan_idx (3 bits) increments on tick, wrapping 7->0.
  - It runs in every state.
- FSM states are OFF, BOOT, RUN and SHUTDOWN. Transitions are evaluated every clk, first match wins:
  - OFF: power_status=1 -> BOOT, msg_cnt<=MSG_TIME-1.
  - BOOT: power_status=0 -> SHUTDOWN, msg_cnt<=MSG_TIME-1; else if msg_cnt=0 -> RUN; else msg_cnt decrements.
  - RUN: power_status=0 -> SHUTDOWN, msg_cnt<=MSG_TIME-1.
  - SHUTDOWN: power_status=1 -> BOOT, msg_cnt<=MSG_TIME-1; else if msg_cnt=0 -> OFF; else msg_cnt decrements.
  - Net effect: BOOT and SHUTDOWN each dwell exactly MSG_TIME cycles unless aborted; an abort reloads the full dwell in the new state.
  - If power_status=1 while rst is released, the first active edge enters BOOT.
- Digit content for digit d = scan_idx, per state:
  - OFF: seg_en=8'h00, seg_out=8'h00.
  - BOOT: d1='O' (8'b1111_1100), d0='n' (8'b0010_1010); all other digits blank (8'h00).
  - SHUTDOWN: d2='O' (8'b1111_1100), d1='F' (8'b1000_1110), d0='F'; all other digits blank.
  - RUN: d7 = hex of selection[7:4]; d6 = hex of selection[3:0]; d5 and d4 blank.
  - RUN: d3/d2 = tens/units of left_time; d1/d0 = tens/units of right_time.
  - RUN decimal rule: a value >99 saturates and displays "99".
  - Hex font: 0 FC, 1 60, 2 DA, 3 F2, 4 66, 5 B6, 6 BE, 7 E0, 8 FE, 9 E6, A EE, b 3E, C 9C, d 7A, E 9E, F 8E. dp is always 0.
- Outputs are registered. seg_en/seg_out on clk edge k+1 reflect scan_idx, state and inputs at edge k (1-cycle latency).
  - In any non-OFF state, seg_en = 8'h01 << scan_idx, even when that digit's pattern is blank.
- Inputs are sampled live every cycle; no latching. A value change shows on the next refresh of that digit.
- Mid-scan state change: the new content applies from the next clk; scan_idx is not reset.
- Reset mid-operation: all outputs go to 8'h00 immediately (async); the FSM restarts in OFF.

Test Plan (SCAN_DIV=4, MSG_TIME=20):
1. Reset held, power_status=0 -> seg_en=8'h00 and seg_out=8'h00 during and after release; state remains OFF for 100 cycles.
2. power_status 0->1 at cycle t -> from t+2, in the slot with seg_en=8'h02 seg_out=8'hFC, and with seg_en=8'h01 seg_out=8'h2A; other slots show 8'h00. At t+21 the FSM is in RUN.
3. RUN with selection=8'h3A, left_time=8'd57, right_time=8'd150 -> d7=F2, d6=EE, d5/d4=00, d3=B6, d2=E0, d1=E6, d0=E6; the digits are verified across one full 32-cycle scan.
4. RUN, power_status->0 -> SHUTDOWN: d2=FC, d1=8E, d0=8E for 20 cycles, then seg_en=8'h00.
5. During BOOT, power_status drops at msg_cnt=10 and returns to 1 five cycles later -> sequence is BOOT->SHUTDOWN->BOOT with full 20-cycle dwells, ending in RUN 20 cycles after the re-rise.
6. rst asserted mid-RUN (async, between edges) -> seg_en and seg_out read 8'h00 within the same cycle; after release with power_status=1 -> BOOT on the first edge.
